// File: rtl/vector_mem_sequencer_if.sv
// rtl/vector_mem_sequencer_if.sv - word-wide data-memory beat port between sequencer and memory
interface vector_mem_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - splits MEM-stage scalar/vector accesses into word beats, stalls the pipeline
// Optional alignment check enabled by defining VSEQ_ALIGN_CHECK_EN.
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic                    req_vector,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*DATA_W-1:0] req_wdata,
    output logic                    stall,
    output logic                    rsp_valid,
    output logic [LANES*DATA_W-1:0] rsp_rdata,
    output logic                    rsp_err,
    vector_mem_sequencer_if.master  mem
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    write_q;
    logic                    vector_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LANES*DATA_W-1:0] wdata_q;
    logic [LANES*DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    accept;
    logic                    beat_done;
    logic                    last_beat;
    logic                    misaligned;

    assign accept    = (state_q == IDLE) && req_valid;
    assign beat_done = (state_q == ACCESS) && mem.mem_ready;
    // A scalar access never advances idx, so its only beat is also its last.
    assign last_beat = vector_q ? (idx_q == IDX_W'(LANES - 1)) : 1'b1;

`ifdef VSEQ_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = req_vector ? ((req_addr % ADDR_W'(4 * LANES)) != '0)
                                   : (req_addr[1:0] != 2'b00);
    assign rsp_err    = rsp_valid && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        rsp_valid     = 1'b0;
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    state_d = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall         = 1'b1;
                mem.mem_en    = 1'b1;
                mem.mem_we    = write_q;
                mem.mem_addr  = addr_q + (ADDR_W'(idx_q) << 2);
                mem.mem_wdata = write_q ? wdata_q[idx_q*DATA_W +: DATA_W] : '0;
                if (mem.mem_ready && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // State is already IDLE under reset; req_valid alone must not raise stall then.
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            vector_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            vector_q <= req_vector;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            idx_q    <= '0;
        end else if (beat_done) begin
            if (!write_q) begin
                rdata_q[idx_q*DATA_W +: DATA_W] <= mem.mem_rdata;
            end
            if (!last_beat) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - directed self-checking bench for vector_mem_sequencer
module tb_vector_mem_sequencer;
    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req_valid;
    logic                    req_write;
    logic                    req_vector;
    logic [ADDR_W-1:0]       req_addr;
    logic [LANES*DATA_W-1:0] req_wdata;
    logic                    stall;
    logic                    rsp_valid;
    logic [LANES*DATA_W-1:0] rsp_rdata;
    logic                    rsp_err;

    vector_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_vector(req_vector),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_words [8];
    logic [31:0] log_addr [8];
    logic [31:0] log_data [8];
    logic        log_we   [8];
    int          beats;
    int          en_cycles;
    int          hold_cyc;
    int          hold_changed;
    logic        stall_log [40];
    logic [127:0] rdata_seen;
    logic        err_seen;
    int          lat;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; drives one request and services its beats.
    task automatic run_req(input logic wr, input logic vec, input logic [31:0] addr,
                           input logic [127:0] wd, input int hold_beat, input int hold_n);
        int          held;
        logic [31:0] h_addr;
        logic [31:0] h_data;
        held = 0; beats = 0; en_cycles = 0; hold_cyc = 0; hold_changed = 0; lat = -1;
        h_addr = '0; h_data = '0;
        req_valid = 1'b1; req_write = wr; req_vector = vec; req_addr = addr; req_wdata = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            mem_if.mem_ready = (beats == hold_beat && held < hold_n) ? 1'b0 : 1'b1;
            mem_if.mem_rdata = (beats < 8) ? rd_words[beats] : 32'h0;
            #1;
            stall_log[cyc] = stall;
            if (mem_if.mem_en) begin
                en_cycles++;
                if (beats == hold_beat) begin
                    if (hold_cyc == 0) begin
                        h_addr = mem_if.mem_addr;
                        h_data = mem_if.mem_wdata;
                    end else if (mem_if.mem_addr !== h_addr || mem_if.mem_wdata !== h_data) begin
                        hold_changed++;
                    end
                    hold_cyc++;
                end
                if (mem_if.mem_ready) begin
                    if (beats < 8) begin
                        log_addr[beats] = mem_if.mem_addr;
                        log_data[beats] = mem_if.mem_wdata;
                        log_we[beats]   = mem_if.mem_we;
                    end
                    beats++;
                end else begin
                    held++;
                end
            end
            if (rsp_valid) begin
                lat = cyc;
                rdata_seen = rsp_rdata;
                err_seen = rsp_err;
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (lat >= 0) break;
        end
        if (lat < 0) begin
            check_eq("rsp_timeout", 1'b1, 1'b0);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_vector = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
        for (int i = 0; i < 8; i++) rd_words[i] = '0;
        #12;
        check_eq("reset_stall", stall, 1'b0);
        check_eq("reset_rsp_valid", rsp_valid, 1'b0);
        check_eq("reset_mem_en", mem_if.mem_en, 1'b0);
        check_eq("reset_mem_addr", mem_if.mem_addr, 32'h0);
        check_eq("reset_rsp_rdata", rsp_rdata, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifndef VSEQ_ALIGN_CHECK_EN
        // Scalar store
        run_req(1'b1, 1'b0, 32'h100, 128'hDEADBEEF, 99, 0);
        check_eq("ss_latency", lat, 2);
        check_eq("ss_beats", beats, 1);
        check_eq("ss_addr", log_addr[0], 32'h100);
        check_eq("ss_wdata", log_data[0], 32'hDEADBEEF);
        check_eq("ss_we", log_we[0], 1'b1);
        check_eq("ss_stall_c0", stall_log[0], 1'b1);
        check_eq("ss_stall_c1", stall_log[1], 1'b1);
        check_eq("ss_stall_done", stall_log[2], 1'b0);
        check_eq("ss_err", err_seen, 1'b0);
        check_eq("ss_rsp_drop", rsp_valid, 1'b0);
`endif

        // Vector load
        rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
        run_req(1'b0, 1'b1, 32'h200, 128'h0, 99, 0);
        check_eq("vl_latency", lat, 5);
        check_eq("vl_beats", beats, 4);
        check_eq("vl_addr0", log_addr[0], 32'h200);
        check_eq("vl_addr1", log_addr[1], 32'h204);
        check_eq("vl_addr2", log_addr[2], 32'h208);
        check_eq("vl_addr3", log_addr[3], 32'h20C);
        check_eq("vl_we", log_we[2], 1'b0);
        check_eq("vl_wdata_zero", log_data[1], 32'h0);
        check_eq("vl_rdata", rdata_seen, 128'h00000044_00000033_00000022_00000011);
        check_eq("vl_err", err_seen, 1'b0);
        check_eq("vl_rdata_held", rsp_rdata, 128'h00000044_00000033_00000022_00000011);

        // Vector store, beat 1 stalled two cycles
        run_req(1'b1, 1'b1, 32'h400, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 1, 2);
        check_eq("vs_latency", lat, 7);
        check_eq("vs_beats", beats, 4);
        check_eq("vs_en_cycles", en_cycles, 6);
        check_eq("vs_hold_cycles", hold_cyc, 3);
        check_eq("vs_hold_changed", hold_changed, 0);
        check_eq("vs_addr1", log_addr[1], 32'h404);
        check_eq("vs_data0", log_data[0], 32'hD0D0D0D0);
        check_eq("vs_data1", log_data[1], 32'hD1D1D1D1);
        check_eq("vs_data3", log_data[3], 32'hD3D3D3D3);
        check_eq("vs_rdata_cleared", rdata_seen, 128'h0);

`ifndef VSEQ_ALIGN_CHECK_EN
        // Vector load wrapping the address space
        run_req(1'b0, 1'b1, 32'hFFFFFFF8, 128'h0, 99, 0);
        check_eq("wr_latency", lat, 5);
        check_eq("wr_addr0", log_addr[0], 32'hFFFFFFF8);
        check_eq("wr_addr1", log_addr[1], 32'hFFFFFFFC);
        check_eq("wr_addr2", log_addr[2], 32'h0);
        check_eq("wr_addr3", log_addr[3], 32'h4);
`else
        // Misaligned scalar load aborts without a beat
        run_req(1'b0, 1'b0, 32'h102, 128'h0, 99, 0);
        check_eq("al_latency", lat, 1);
        check_eq("al_en_cycles", en_cycles, 0);
        check_eq("al_err", err_seen, 1'b1);
        check_eq("al_rdata", rdata_seen, 128'h0);
        run_req(1'b0, 1'b1, 32'h208, 128'h0, 99, 0);
        check_eq("alv_latency", lat, 1);
        check_eq("alv_err", err_seen, 1'b1);
        rd_words[0] = 32'h5A5A5A5A;
        run_req(1'b0, 1'b0, 32'h104, 128'h0, 99, 0);
        check_eq("ok_latency", lat, 2);
        check_eq("ok_err", err_seen, 1'b0);
        check_eq("ok_rdata", rdata_seen, 128'h5A5A5A5A);
`endif

        // Reset during beat 2 of a vector load
        rd_words[0] = 32'hA0; rd_words[1] = 32'hA1; rd_words[2] = 32'hA2; rd_words[3] = 32'hA3;
        req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b1; req_addr = 32'h300; req_wdata = '0;
        mem_if.mem_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            mem_if.mem_rdata = rd_words[beats];
            #1;
            if (mem_if.mem_en && mem_if.mem_ready) beats++;
            @(posedge clk); #1;
        end
        check_eq("rst_reached_beat2", beats, 2);
        check_eq("rst_pre_addr", mem_if.mem_addr, 32'h308);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mem_en", mem_if.mem_en, 1'b0);
        check_eq("rst_mem_we", mem_if.mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_if.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, 128'h0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_words[0] = 32'hCAFE1234; rd_words[1] = 32'hFFFFFFFF;
        run_req(1'b0, 1'b0, 32'h500, 128'h0, 99, 0);
        check_eq("pr_latency", lat, 2);
        check_eq("pr_beats", beats, 1);
        check_eq("pr_addr", log_addr[0], 32'h500);
        check_eq("pr_rdata", rdata_seen, 128'hCAFE1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
